// File: rtl/wave_pwm_dac_if.sv
// ============================================================================
// wave_pwm_dac_if
// ----------------------------------------------------------------------------
// Sample stream handshake between the wave generator (master) and the PWM DAC
// output stage (slave).
//
// Signals:
//   sample_in     signed 16-bit sample (two's complement), master -> slave
//   sample_valid  sample_in offered this cycle, master -> slave
//   sample_ready  slave holding register is empty, slave -> master
// ============================================================================
interface wave_pwm_dac_if;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/wave_pwm_dac.sv
// ============================================================================
// wave_pwm_dac
// ----------------------------------------------------------------------------
// PWM output stage of the waveform generator. Each accepted signed sample is
// arithmetically shifted, saturated to CNT_W bits, converted to offset binary
// and parked in a one-entry holding register. The parked duty is applied at
// the next PWM period boundary; without a new sample the previous duty is
// held (zero-order hold).
//
// Parameters:
//   CNT_W         PWM resolution in bits, period = 2**CNT_W clocks (2..16)
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   en            run request (level)
//   smp           sample stream, slave side (sample_in/valid/ready)
//   shift         arithmetic right shift applied before saturation
//   clr_flags     clears overrun and clip (a simultaneous set wins)
//   pwm_out       PWM pin
//   duty_out      duty currently in force (offset binary)
//   period_start  one-cycle pulse in the first cycle of each period (RUN)
//   overrun       sticky: sample offered while the holding register was full
//   clip          sticky: an accepted sample saturated
// ============================================================================
module wave_pwm_dac #(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    wave_pwm_dac_if.slave      smp,
    input  logic [3:0]         shift,
    input  logic               clr_flags,
    output logic               pwm_out,
    output logic [CNT_W-1:0]   duty_out,
    output logic               period_start,
    output logic               overrun,
    output logic               clip
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    localparam int               SAT_MAX  = 2 ** (CNT_W - 1) - 1;
    localparam int               SAT_MIN  = -(2 ** (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_LAST = '1;
    localparam logic [CNT_W-1:0] DUTY_MID = {1'b1, {(CNT_W - 1){1'b0}}};

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   duty_active;
    logic [CNT_W-1:0]   pend;
    logic               pend_full;

    logic signed [15:0] shifted;
    logic [CNT_W-1:0]   sat_val;
    logic               sat_hit;
    logic [CNT_W-1:0]   conv_duty;
    logic               accept;
    logic               drop;
    logic               wrap;
    logic               boundary;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   duty_nxt;

    // ------------------------------------------------------------------------
    // Sample conversion: shift, saturate, offset binary
    // ------------------------------------------------------------------------
    assign shifted = $signed(smp.sample_in) >>> shift;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        sat_hit = 1'b0;
        sat_val = shifted[CNT_W-1:0];
        if (int'(shifted) > SAT_MAX) begin
            sat_val = {1'b0, {(CNT_W - 1){1'b1}}};
            sat_hit = 1'b1;
        end else if (int'(shifted) < SAT_MIN) begin
            sat_val = {1'b1, {(CNT_W - 1){1'b0}}};
            sat_hit = 1'b1;
        end
    end

    // Adding half scale to a two's-complement value is just an MSB flip.
    assign conv_duty = {~sat_val[CNT_W-1], sat_val[CNT_W-2:0]};

    assign smp.sample_ready = !pend_full;
    assign accept           = smp.sample_valid && !pend_full;
    assign drop             = smp.sample_valid &&  pend_full;

    // ------------------------------------------------------------------------
    // Period boundary and next-cycle duty
    // ------------------------------------------------------------------------
    assign wrap    = (cnt == CNT_LAST);
    assign cnt_inc = cnt + 1'b1;

    // A STOP that sees en again rejoins RUN, so its wrap is a real boundary.
    assign boundary = ((state == IDLE) && en)
                   || ((state == RUN)  && wrap)
                   || ((state == STOP) && en && wrap);

    // The boundary load uses pend as it was before the edge; a sample taken
    // on the same edge only sets pend_full and waits one more period.
    assign duty_nxt = (boundary && pend_full) ? pend : duty_active;

    // ------------------------------------------------------------------------
    // Holding register payload
    // ------------------------------------------------------------------------
    // NOTE: pend is a plain data register without reset; pend_full qualifies
    // it, so whatever it holds after reset is never used.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend <= conv_duty;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM, counter, registered outputs and flags
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side reads the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            duty_active  <= DUTY_MID;
            pend_full    <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            overrun      <= 1'b0;
            clip         <= 1'b0;
        end else begin
            // Holding register occupancy: accept and boundary-load never
            // coincide because accept requires an empty register.
            if (accept) begin
                pend_full <= 1'b1;
            end else if (boundary && pend_full) begin
                pend_full <= 1'b0;
            end

            duty_active <= duty_nxt;

            overrun <= (overrun && !clr_flags) || drop;
            clip    <= (clip    && !clr_flags) || (accept && sat_hit);

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en) begin
                        state        <= RUN;
                        period_start <= 1'b1;
                        pwm_out      <= (duty_nxt != '0);
                    end else begin
                        period_start <= 1'b0;
                        pwm_out      <= 1'b0;
                    end
                end

                RUN: begin
                    cnt          <= cnt_inc;
                    period_start <= wrap;
                    pwm_out      <= (cnt_inc < duty_nxt);
                    if (!en) begin
                        state <= STOP;
                    end
                end

                STOP: begin
                    if (en) begin
                        state        <= RUN;
                        cnt          <= cnt_inc;
                        period_start <= wrap;
                        pwm_out      <= (cnt_inc < duty_nxt);
                    end else if (wrap) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        period_start <= 1'b0;
                        pwm_out      <= 1'b0;
                    end else begin
                        cnt          <= cnt_inc;
                        period_start <= 1'b0;
                        pwm_out      <= (cnt_inc < duty_nxt);
                    end
                end

                default: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    period_start <= 1'b0;
                    pwm_out      <= 1'b0;
                end
            endcase
        end
    end

    assign duty_out = duty_active;

endmodule

// File: tb/tb_wave_pwm_dac.sv
// ============================================================================
// tb_wave_pwm_dac
// ----------------------------------------------------------------------------
// Directed bench for wave_pwm_dac (CNT_W = 8). Expected duties are computed
// from the sample by an integer reference model, queued when the sample is
// driven and popped at the period boundary where they must take effect.
// ============================================================================
module tb_wave_pwm_dac;

    localparam int CNT_W  = 8;
    localparam int PERIOD = 2 ** CNT_W;

    logic             clk;
    logic             rst;
    logic             en;
    logic [3:0]       shift;
    logic             clr_flags;
    logic             pwm_out;
    logic [CNT_W-1:0] duty_out;
    logic             period_start;
    logic             overrun;
    logic             clip;

    wave_pwm_dac_if bus ();

    wave_pwm_dac #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .smp          (bus),
        .shift        (shift),
        .clr_flags    (clr_flags),
        .pwm_out      (pwm_out),
        .duty_out     (duty_out),
        .period_start (period_start),
        .overrun      (overrun),
        .clip         (clip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               tests = 0;
    int               fails = 0;
    logic [CNT_W-1:0] exp_q[$];
    logic [CNT_W-1:0] exp_duty;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are then read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reference conversion in plain integer arithmetic.
    function automatic logic [CNT_W-1:0] model(input logic [15:0] x,
                                               input int sh,
                                               output bit clipped);
        int v;
        v = int'($signed(x));
        v = v >>> sh;
        clipped = 1'b0;
        if (v > PERIOD / 2 - 1) begin
            v = PERIOD / 2 - 1;
            clipped = 1'b1;
        end else if (v < -(PERIOD / 2)) begin
            v = -(PERIOD / 2);
            clipped = 1'b1;
        end
        return CNT_W'(v + PERIOD / 2);
    endfunction

    // Offer one sample for one cycle; queue its duty if it should be taken.
    task automatic send(input logic [15:0] x, input int sh, input bit exp_acc);
        bit               c;
        logic [CNT_W-1:0] d;
        d = model(x, sh, c);
        bus.sample_in    = x;
        bus.sample_valid = 1'b1;
        shift            = 4'(sh);
        check("sample_ready_before_offer", 32'(bus.sample_ready), 32'(exp_acc));
        tick();
        bus.sample_valid = 1'b0;
        if (exp_acc) exp_q.push_back(d);
    endtask

    // Bounded wait for the next period_start cycle.
    task automatic wait_ps(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (period_start !== 1'b1 && n < budget);
        check("wait_period_start", 32'(period_start), 32'd1);
    endtask

    // In a period_start cycle: the scoreboard head (if any) must now be live.
    task automatic on_boundary();
        if (exp_q.size() > 0) exp_duty = exp_q.pop_front();
        check("duty_out_at_boundary", 32'(duty_out), 32'(exp_duty));
    endtask

    // Starting in a period_start cycle, observe one full period.
    task automatic measure(input logic [CNT_W-1:0] d);
        int highs;
        int starts;
        int errs;
        highs  = 0;
        starts = 0;
        errs   = 0;
        for (int i = 0; i < PERIOD; i++) begin
            highs  += int'(pwm_out);
            starts += int'(period_start);
            if (pwm_out !== (i < int'(d))) errs++;
            tick();
        end
        check("pwm_high_cycles", 32'(highs), 32'(d));
        check("pwm_shape_errors", 32'(errs), 32'd0);
        check("period_starts_in_period", 32'(starts), 32'd1);
        check("period_start_after_period", 32'(period_start), 32'd1);
    endtask

    task automatic check_reset_values();
        check("rst_duty_out", 32'(duty_out), 32'(PERIOD / 2));
        check("rst_sample_ready", 32'(bus.sample_ready), 32'd1);
        check("rst_pwm_out", 32'(pwm_out), 32'd0);
        check("rst_period_start", 32'(period_start), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_clip", 32'(clip), 32'd0);
    endtask

    initial begin
        int idle_act;
        int highs;
        int starts;

        rst              = 1'b1;
        en               = 1'b0;
        shift            = 4'd0;
        clr_flags        = 1'b0;
        bus.sample_in    = 16'h0000;
        bus.sample_valid = 1'b0;
        exp_duty         = CNT_W'(PERIOD / 2);

        // ---- 1: reset, then free run at mid-scale --------------------------
        ticks(2);
        rst = 1'b0;
        check_reset_values();
        en = 1'b1;
        tick();
        check("startup_period_start", 32'(period_start), 32'd1);
        check("startup_pwm_out", 32'(pwm_out), 32'd1);
        on_boundary();
        measure(exp_duty);

        // ---- 2: full-scale positive and negative, shift 8 ------------------
        on_boundary();
        ticks(50);
        send(16'h7FFF, 8, 1'b1);
        check("ready_after_accept", 32'(bus.sample_ready), 32'd0);
        wait_ps(PERIOD + 4);
        on_boundary();
        check("clip_after_7fff", 32'(clip), 32'd0);
        measure(exp_duty);
        ticks(40);
        send(16'h8000, 8, 1'b1);
        wait_ps(PERIOD + 4);
        on_boundary();
        measure(exp_duty);
        check("clip_after_8000", 32'(clip), 32'd0);

        // ---- 3: clipping and flag clear priority ---------------------------
        ticks(5);
        send(16'h0100, 0, 1'b1);
        check("clip_set", 32'(clip), 32'd1);
        wait_ps(PERIOD + 4);
        on_boundary();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("clip_cleared", 32'(clip), 32'd0);
        ticks(3);
        clr_flags = 1'b1;
        send(16'h0100, 0, 1'b1);
        clr_flags = 1'b0;
        check("clip_set_beats_clear", 32'(clip), 32'd1);
        wait_ps(PERIOD + 4);
        on_boundary();

        // ---- 4: overrun, ready timing, accept on the boundary edge ---------
        ticks(10);
        send(16'h1000, 8, 1'b1);
        check("ready_low_pend_full", 32'(bus.sample_ready), 32'd0);
        ticks(10);
        send(16'h2000, 8, 1'b0);
        check("overrun_set", 32'(overrun), 32'd1);
        wait_ps(PERIOD + 4);
        on_boundary();
        check("ready_in_period_start", 32'(bus.sample_ready), 32'd1);
        ticks(PERIOD - 1);
        send(16'h3000, 8, 1'b1);
        check("edge_accept_period_start", 32'(period_start), 32'd1);
        check("edge_accept_duty_held", 32'(duty_out), 32'(exp_duty));
        check("edge_accept_ready_low", 32'(bus.sample_ready), 32'd0);
        wait_ps(PERIOD + 4);
        on_boundary();

        // ---- 5: stop completes the period, restart keeps duty --------------
        ticks(100);
        en = 1'b0;
        tick();
        highs  = 0;
        starts = 0;
        for (int i = 0; i < PERIOD - 101; i++) begin
            highs  += int'(pwm_out);
            starts += int'(period_start);
            tick();
        end
        check("stop_tail_highs", 32'(highs), 32'(int'(exp_duty) - 101));
        check("stop_tail_starts", 32'(starts), 32'd0);
        idle_act = 0;
        for (int i = 0; i < 20; i++) begin
            idle_act += int'(pwm_out) + int'(period_start);
            tick();
        end
        check("idle_quiet", 32'(idle_act), 32'd0);
        en = 1'b1;
        tick();
        check("restart_period_start", 32'(period_start), 32'd1);
        check("restart_duty_kept", 32'(duty_out), 32'(exp_duty));
        check("restart_pwm_out", 32'(pwm_out), 32'd1);

        // ---- 6: reset mid-period drops the buffered sample -----------------
        ticks(20);
        send(16'h4000, 8, 1'b1);
        check("scoreboard_one_pending", 32'(exp_q.size()), 32'd1);
        ticks(10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_duty = CNT_W'(PERIOD / 2);
        check_reset_values();
        wait_ps(4);
        on_boundary();
        measure(exp_duty);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wave_pwm_dac.md
# wave_pwm_dac

Output stage of the waveform generator. It takes the signed 16-bit sample stream produced by the wave generator (`wave_out`) and drives a single-bit PWM pin that an external RC filter turns into an analog voltage. Each accepted sample is scaled, saturated and converted to offset binary, then buffered in a one-entry holding register. The buffered value is applied at the next PWM period boundary. If no new sample arrives, the previous duty is held for the next period (zero-order hold).

## Interface
- `CNT_W`, default 8: PWM resolution in bits; period = 2^CNT_W clocks.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `en`  in  1  run request; level-sensitive.
- `sample_in`  in  16  signed sample (two's complement).
- `sample_valid`  in  1  `sample_in` offered this cycle. The source is free-running and is not required to hold.
- `sample_ready`  out  1  holding register empty; equals `!pend_full`.
- `shift`  in  4  arithmetic right-shift applied before saturation (0..15).
- `clr_flags`  in  1  clears `overrun` and `clip`.
- `pwm_out`  out  1  PWM output.
- `duty_out`  out  CNT_W  duty currently in force (offset binary).
- `period_start`  out  1  one-cycle pulse in the first cycle of each PWM period.
- `overrun`  out  1  sticky: a sample was offered while `sample_ready` = 0.
- `clip`  out  1  sticky: an accepted sample saturated.

## Operation
- **Conversion on accept** (`sample_valid && sample_ready`):
  - s = `sample_in` >>> `shift` (sign-preserving).
  - Saturate s to [-2^(CNT_W-1), 2^(CNT_W-1)-1]. If saturation occurred, set `clip`.
  - duty = saturated s + 2^(CNT_W-1), with MSB inverted to give offset binary. For CNT_W=8: -128→0, 0→128, 127→255.
  - Store duty in `pend` and set `pend_full`.
- **Overrun:** `sample_valid && !sample_ready` discards the sample and sets `overrun`.
- **Flags:** `clr_flags` clears both flags. If a set event occurs in the same cycle, set wins.
- **State machine** (IDLE, RUN, STOP):
  - IDLE: `cnt` = 0, `pwm_out` = 0, no `period_start`. When `en` = 1, go to RUN.
  - RUN: `cnt` increments each cycle and wraps 2^CNT_W-1 → 0. When `en` = 0, go to STOP.
  - STOP: the current period completes. On the edge where `cnt` would wrap, go to IDLE with `cnt` = 0. If `en` returns to 1 while in STOP, go back to RUN and the wrap proceeds normally.
- **Period boundary** = the IDLE→RUN edge, or the `cnt` wrap edge while in RUN.
  - At the boundary, if `pend_full`: `duty_active` ← `pend` and `pend_full` ← 0. Otherwise `duty_active` is retained.
  - The boundary load uses the `pend` contents from before the edge. A sample accepted on that same edge waits a full period.
- **PWM output:** in RUN/STOP, `pwm_out` is high in exactly the first `duty_active` cycles of each period, starting with the `period_start` cycle.
  - duty 0 → never high.
  - duty 2^CNT_W-1 → high in all but the last cycle of the period.
- `duty_out` = `duty_active`.
- Samples are accepted in every state. `pend` survives IDLE.

## Timing
- All outputs are registered. No combinational path from input to output except `sample_ready`, which is derived only from `pend_full`.
- **Reset values:** state IDLE, `cnt` 0, `duty_active`/`duty_out` 2^(CNT_W-1), `pend_full` 0, `sample_ready` 1, `pwm_out` 0, `period_start` 0, `overrun` 0, `clip` 0.
- **Reset mid-operation:** the buffered sample is lost, and outputs take their reset values in the cycle after `rst` is sampled.
- **Start-up:** `en` rises at edge E0. The first `period_start` and the first possibly-high `pwm_out` appear in the cycle after E0.
- **Latency:** a sample accepted at edge E reaches `pwm_out`/`duty_out` at the first boundary strictly after E. That is at most 2^CNT_W clocks later while running.
- **Boundary with pend full:** `sample_ready` is 0 in the last cycle of the period, so a sample offered then is dropped (`overrun`). `sample_ready` returns to 1 in the `period_start` cycle.
- `period_start` repeats every 2^CNT_W cycles while in RUN. No pulse is issued in STOP or IDLE.

## Test plan
1. Reset, `en`=1, no samples → `period_start` every 256 cycles. `pwm_out` is high 128 cycles per period, beginning in the `period_start` cycle. `duty_out`=128.
2. `shift`=8:
   - `sample_in`=0x7FFF mid-period → at the next boundary `duty_out`=255 and `pwm_out` is high 255/256 cycles; `clip`=0.
   - Then 0x8000 → `duty_out`=0 and `pwm_out` stays low.
3. `shift`=0, `sample_in`=0x0100 → `duty_out`=255 and `clip`=1. Pulse `clr_flags` → `clip`=0. `clr_flags` asserted together with a new clipping sample → `clip` stays 1.
4. Two samples (0x1000, 0x2000, `shift`=8) in the same period → the first is accepted and `sample_ready`=0. The second is dropped and `overrun`=1. Next period `duty_out`=144. `sample_ready`=1 in the `period_start` cycle.
5. `en` dropped at `cnt`=100 → the period completes through `cnt`=255, then IDLE. `pwm_out`=0 and no `period_start`. Re-raise `en` → `period_start` in the following cycle, and `duty_out` is unchanged.
6. `rst` asserted mid-period with `pend_full`=1 → next cycle shows all reset values. The buffered sample is never applied.
